// File: rtl/multicycle_core_if.sv
// Memory bus between the multicycle core (master) and its memory (slave).
// A transfer completes on the rising edge where mem_req and mem_ack are both high.
interface multicycle_core_if #(
   parameter int AW = 16
);
   logic          mem_req;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [31:0]   mem_wdata;
   logic [31:0]   mem_rdata;
   logic          mem_ack;

   modport master (
      output mem_req, mem_we, mem_addr, mem_wdata,
      input  mem_rdata, mem_ack
   );

   modport slave (
      input  mem_req, mem_we, mem_addr, mem_wdata,
      output mem_rdata, mem_ack
   );
endinterface

// File: rtl/multicycle_core.sv
// Multicycle 32-bit core: FETCH/DECODE/EXEC/MEM/WB over a single shared memory bus.
// Address faults, illegal opcodes and bus timeouts park the core in HALT with err set.
module multicycle_core #(
   parameter int              AW       = 16,
   parameter logic [AW-1:0]   RESET_PC = '0,
   parameter int              LINK_REG = 31,
   parameter int              WAIT_MAX = 255
) (
   input  logic               clk,
   input  logic               rst_n,
   multicycle_core_if.master  mem,
   output logic               retire,
   output logic               halted,
   output logic               err,
   output logic [AW-1:0]      dbg_pc
);

   typedef enum logic [2:0] {
      S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
   } state_t;

   localparam logic [5:0] OP_R    = 6'h00;
   localparam logic [5:0] OP_BEQ  = 6'h04;
   localparam logic [5:0] OP_ORI  = 6'h0D;
   localparam logic [5:0] OP_BALN = 6'h1B;
   localparam logic [5:0] OP_LW   = 6'h23;
   localparam logic [5:0] OP_SW   = 6'h2B;
   localparam logic [5:0] OP_HALT = 6'h3F;
   localparam logic [5:0] F_ADD   = 6'h20;
   localparam logic [5:0] F_SUB   = 6'h22;
   localparam logic [5:0] F_AND   = 6'h24;
   localparam logic [5:0] F_OR    = 6'h25;
   localparam logic [5:0] F_SLT   = 6'h2A;
   localparam logic [4:0]    LINK   = 5'(LINK_REG);
   localparam logic [31:0]   WMAX   = 32'(WAIT_MAX);
   localparam logic [AW-1:0] PC_INC = AW'(4);

   state_t         state_q, state_d;
   logic [AW-1:0]  pc_q;
   logic [31:0]    ir_q, a_q, b_q, res_q, wcnt_q;
   logic           n_q, z_q, err_q;
   logic [31:0]    rf_q [32];

   logic [5:0]     op, funct;
   logic [4:0]     rs, rt, rd, wb_dst;
   logic [31:0]    simm, zimm, alu_res, rd_rs, rd_rt;
   logic           is_r, is_lw, is_sw, is_ori, is_beq, is_baln, is_halt, legal;
   logic           ea_bad, br_taken, acc, stall_ovf;
   logic [AW-1:0]  br_tgt;
   logic           unused_bits;

   function automatic logic [31:0] alu_r(input logic [5:0] f,
                                         input logic signed [31:0] x,
                                         input logic signed [31:0] y);
      case (f)
         F_ADD:   return x + y;
         F_SUB:   return x - y;
         F_AND:   return x & y;
         F_OR:    return x | y;
         F_SLT:   return (x < y) ? 32'd1 : 32'd0;
         default: return '0;
      endcase
   endfunction

   // Misaligned, or any bit above the bus width set.
   function automatic logic addr_bad(input logic [31:0] ea);
      return (ea[1:0] != 2'b00) || ((ea >> AW) != 32'd0);
   endfunction

   assign op      = ir_q[31:26];
   assign rs      = ir_q[25:21];
   assign rt      = ir_q[20:16];
   assign rd      = ir_q[15:11];
   assign funct   = ir_q[5:0];
   assign simm    = {{16{ir_q[15]}}, ir_q[15:0]};
   assign zimm    = {16'h0000, ir_q[15:0]};
   assign is_r    = (op == OP_R) && (funct inside {F_ADD, F_SUB, F_AND, F_OR, F_SLT});
   assign is_lw   = (op == OP_LW);
   assign is_sw   = (op == OP_SW);
   assign is_ori  = (op == OP_ORI);
   assign is_beq  = (op == OP_BEQ);
   assign is_baln = (op == OP_BALN);
   assign is_halt = (op == OP_HALT);
   assign legal   = is_r || is_lw || is_sw || is_ori || is_beq || is_baln;
   assign wb_dst  = (op == OP_R) ? rd : rt;
   assign rd_rs   = (rs == 5'd0) ? 32'd0 : rf_q[rs];
   assign rd_rt   = (rt == 5'd0) ? 32'd0 : rf_q[rt];

   always_comb begin
      alu_res = a_q + simm;
      if (is_r)        alu_res = alu_r(funct, a_q, b_q);
      else if (is_ori) alu_res = a_q | zimm;
   end

   // pc_q already points at the next sequential instruction during EXEC.
   assign br_tgt    = AW'(32'(pc_q) + (simm << 2));
   assign br_taken  = (is_beq && (a_q == b_q)) || (is_baln && n_q);
   assign ea_bad    = addr_bad(alu_res);
   assign acc       = (state_q == S_FETCH) || (state_q == S_MEM);
   assign stall_ovf = acc && !mem.mem_ack && (wcnt_q == WMAX);
   assign unused_bits = ^{ir_q[10:6], z_q};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_FETCH;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_FETCH:  if (mem.mem_ack) state_d = S_DECODE;
                   else if (stall_ovf) state_d = S_HALT;
         S_DECODE: state_d = (is_halt || !legal) ? S_HALT : S_EXEC;
         S_EXEC:   if (is_r || is_ori)     state_d = S_WB;
                   else if (is_lw || is_sw) state_d = ea_bad ? S_HALT : S_MEM;
                   else                     state_d = S_FETCH;
         S_MEM:    if (mem.mem_ack) state_d = is_lw ? S_WB : S_FETCH;
                   else if (stall_ovf) state_d = S_HALT;
         S_WB:     state_d = S_FETCH;
         default:  state_d = S_HALT;
      endcase
   end

   // Outputs are forced to their idle values for as long as reset is held.
   always_comb begin
      mem.mem_req   = 1'b0;
      mem.mem_we    = 1'b0;
      mem.mem_addr  = '0;
      mem.mem_wdata = '0;
      retire        = 1'b0;
      if (rst_n) begin
         case (state_q)
            S_FETCH: begin
               mem.mem_req  = 1'b1;
               mem.mem_addr = pc_q;
            end
            S_DECODE: retire = is_halt;
            S_EXEC:   retire = is_beq || is_baln;
            S_MEM: begin
               mem.mem_req   = 1'b1;
               mem.mem_we    = is_sw;
               mem.mem_addr  = res_q[AW-1:0];
               mem.mem_wdata = is_sw ? b_q : 32'd0;
               retire        = is_sw && mem.mem_ack;
            end
            S_WB:     retire = 1'b1;
            default:  retire = 1'b0;
         endcase
      end
   end

   assign halted = (state_q == S_HALT);
   assign err    = err_q;
   assign dbg_pc = pc_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q   <= RESET_PC;
         ir_q   <= '0;
         a_q    <= '0;
         b_q    <= '0;
         res_q  <= '0;
         wcnt_q <= '0;
         n_q    <= 1'b0;
         z_q    <= 1'b0;
         err_q  <= 1'b0;
         for (int i = 0; i < 32; i++) rf_q[i] <= '0;
      end else begin
         wcnt_q <= (acc && !mem.mem_ack) ? wcnt_q + 32'd1 : 32'd0;
         case (state_q)
            S_FETCH: begin
               if (mem.mem_ack) begin
                  ir_q <= mem.mem_rdata;
                  pc_q <= pc_q + PC_INC;
               end else if (stall_ovf) begin
                  err_q <= 1'b1;
               end
            end
            S_DECODE: begin
               a_q <= rd_rs;
               b_q <= rd_rt;
               if (!is_halt && !legal) err_q <= 1'b1;
            end
            S_EXEC: begin
               res_q <= alu_res;
               if (is_r || is_ori) begin
                  n_q <= alu_res[31];
                  z_q <= (alu_res == 32'd0);
               end
               if (br_taken) pc_q <= br_tgt;
               if (is_baln && n_q && (LINK != 5'd0)) rf_q[LINK] <= 32'(pc_q);
               if ((is_lw || is_sw) && ea_bad) err_q <= 1'b1;
            end
            S_MEM: begin
               if (mem.mem_ack) begin
                  if (is_lw) res_q <= mem.mem_rdata;
               end else if (stall_ovf) begin
                  err_q <= 1'b1;
               end
            end
            S_WB: if (wb_dst != 5'd0) rf_q[wb_dst] <= res_q;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_multicycle_core.sv
// Directed bench for multicycle_core: table of single-ALU-op programs plus
// hand-written multi-cycle sequences (stalls, branches, faults, mid-access reset).
module tb_multicycle_core;
   localparam int AW   = 16;
   localparam int WMAX = 10;
   localparam logic [31:0] HALT = 32'hFC00_0000;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic           retire, halted, err;
   logic [AW-1:0]  dbg_pc;

   multicycle_core_if #(.AW(AW)) bus ();

   multicycle_core #(.AW(AW), .RESET_PC(16'h0000), .LINK_REG(31), .WAIT_MAX(WMAX)) dut (
      .clk(clk), .rst_n(rst_n), .mem(bus),
      .retire(retire), .halted(halted), .err(err), .dbg_pc(dbg_pc)
   );

   always #5 clk = ~clk;

   logic [31:0] mem [64];
   int          total = 0, bad = 0;
   int          cyc = 0, ret_cnt = 0, req_cyc = 0, halt_cyc = -1, wr_cnt = 0, viol = 0;
   int          stamps [$];
   logic [31:0] last_waddr, last_wdata;
   logic [15:0] slow_addr = 16'hFFFF;
   int          slow_dly = 0;
   logic        p_req = 1'b0, p_ack = 1'b0, p_we = 1'b0;
   logic [AW-1:0] p_addr;
   logic [31:0] p_wd;

   typedef struct {
      logic [31:0] ins;
      logic [31:0] a;
      logic [31:0] b;
      int          dst;
      logic [31:0] exp;
   } vec_t;
   vec_t tbl [11];

   function automatic logic [31:0] r_ins(int rs, int rt, int rd, logic [5:0] f);
      return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'd0, f};
   endfunction

   function automatic logic [31:0] i_ins(logic [5:0] op, int rs, int rt, logic [15:0] imm);
      return {op, 5'(rs), 5'(rt), imm};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic clear_mem();
      for (int i = 0; i < 64; i++) mem[i] = 32'd0;
   endtask

   task automatic start_run();
      rst_n = 1'b0;
      @(negedge clk);
      @(negedge clk);
      ret_cnt = 0; req_cyc = 0; halt_cyc = -1; wr_cnt = 0; viol = 0;
      last_waddr = 32'd0; last_wdata = 32'd0; p_req = 1'b0;
      stamps.delete();
      rst_n = 1'b1;
   endtask

   task automatic wait_halt(input string name, input int budget);
      int n = 0;
      while (halt_cyc < 0 && n < budget) begin
         @(negedge clk);
         n++;
      end
      #4;
      chk({name, "_halt_reached"}, {31'd0, halt_cyc >= 0}, 32'd1);
   endtask

   // Memory slave: acks after slow_dly stall cycles when addressing slow_addr, else at once.
   initial begin
      int wc = 0;
      bus.mem_ack = 1'b0;
      bus.mem_rdata = 32'd0;
      forever begin
         @(negedge clk);
         #1;
         if (bus.mem_ack) wc = 0;
         if (!rst_n || !bus.mem_req) begin
            bus.mem_ack = 1'b0;
            wc = 0;
         end else if (wc >= ((bus.mem_addr == slow_addr) ? slow_dly : 0)) begin
            bus.mem_ack = 1'b1;
            bus.mem_rdata = mem[bus.mem_addr[7:2]];
            if (bus.mem_we) begin
               mem[bus.mem_addr[7:2]] = bus.mem_wdata;
               wr_cnt++;
               last_waddr = 32'(bus.mem_addr);
               last_wdata = bus.mem_wdata;
            end
         end else begin
            bus.mem_ack = 1'b0;
            wc++;
         end
      end
   end

   initial forever begin
      @(posedge clk);
      if (!rst_n) cyc = 0;
      else cyc++;
   end

   initial forever begin
      @(negedge clk);
      #3;
      if (rst_n) begin
         if (retire) begin
            ret_cnt++;
            stamps.push_back(cyc);
         end
         if (bus.mem_req) req_cyc++;
         if (p_req && !p_ack && bus.mem_req &&
             (bus.mem_addr != p_addr || bus.mem_we != p_we || bus.mem_wdata != p_wd)) viol++;
         if (halted && halt_cyc < 0) halt_cyc = cyc;
         p_req = bus.mem_req; p_ack = bus.mem_ack; p_we = bus.mem_we;
         p_addr = bus.mem_addr; p_wd = bus.mem_wdata;
      end
   end

   initial begin
      int r;
      tbl[0]  = '{r_ins(1, 2, 3, 6'h20), 32'd5,          32'd7,          3, 32'd12};
      tbl[1]  = '{r_ins(1, 2, 3, 6'h20), 32'hFFFF_FFFF,  32'd2,          3, 32'd1};
      tbl[2]  = '{r_ins(1, 2, 3, 6'h22), 32'd5,          32'd7,          3, 32'hFFFF_FFFE};
      tbl[3]  = '{r_ins(1, 2, 3, 6'h22), 32'h8000_0000,  32'd1,          3, 32'h7FFF_FFFF};
      tbl[4]  = '{r_ins(1, 2, 3, 6'h24), 32'hF0F0_1234,  32'h0FF0_FF00,  3, 32'h00F0_1200};
      tbl[5]  = '{r_ins(1, 2, 3, 6'h25), 32'hF000_0001,  32'h0000_0F00,  3, 32'hF000_0F01};
      tbl[6]  = '{r_ins(1, 2, 3, 6'h2A), 32'h8000_0000,  32'd1,          3, 32'd1};
      tbl[7]  = '{r_ins(1, 2, 3, 6'h2A), 32'd1,          32'h8000_0000,  3, 32'd0};
      tbl[8]  = '{r_ins(1, 2, 3, 6'h2A), 32'd7,          32'd7,          3, 32'd0};
      tbl[9]  = '{i_ins(6'h0D, 1, 3, 16'h8001), 32'h1234_0000, 32'd0,   3, 32'h1234_8001};
      tbl[10] = '{r_ins(1, 2, 0, 6'h20), 32'd5,          32'd7,          0, 32'd0};

      // Outputs while reset is held
      repeat (2) @(negedge clk);
      #1;
      chk("rst_mem_req", {31'd0, bus.mem_req}, 32'd0);
      chk("rst_mem_we", {31'd0, bus.mem_we}, 32'd0);
      chk("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
      chk("rst_mem_wdata", bus.mem_wdata, 32'd0);
      chk("rst_flags", {29'd0, retire, halted, err}, 32'd0);
      chk("rst_dbg_pc", 32'(dbg_pc), 32'd0);

      // Table: lw $1 / lw $2 / op / halt
      for (int i = 0; i < 11; i++) begin
         clear_mem();
         mem[0] = i_ins(6'h23, 0, 1, 16'h0040);
         mem[1] = i_ins(6'h23, 0, 2, 16'h0044);
         mem[2] = tbl[i].ins;
         mem[3] = HALT;
         mem[16] = tbl[i].a;
         mem[17] = tbl[i].b;
         start_run();
         wait_halt($sformatf("vec%0d", i), 60);
         chk($sformatf("vec%0d_result", i), dut.rf_q[tbl[i].dst], tbl[i].exp);
         chk($sformatf("vec%0d_halt_cycle", i), 32'(halt_cyc), 32'd16);
         chk($sformatf("vec%0d_err", i), {31'd0, err}, 32'd0);
      end

      // ori/ori/add/halt with zero-wait memory
      clear_mem();
      mem[0] = i_ins(6'h0D, 0, 1, 16'd5);
      mem[1] = i_ins(6'h0D, 0, 2, 16'd7);
      mem[2] = r_ins(1, 2, 3, 6'h20);
      mem[3] = HALT;
      start_run();
      #1;
      chk("first_fetch_req", {31'd0, bus.mem_req}, 32'd1);
      chk("first_fetch_addr", 32'(bus.mem_addr), 32'd0);
      wait_halt("prog1", 60);
      chk("prog1_r3", dut.rf_q[3], 32'd12);
      chk("prog1_retires", 32'(ret_cnt), 32'd4);
      chk("prog1_halt_cycle", 32'(halt_cyc), 32'd14);
      chk("prog1_halted_err", {30'd0, halted, err}, 32'b10);

      // sw/lw with 3 stall cycles on the data word at 8
      clear_mem();
      mem[0] = i_ins(6'h0D, 0, 3, 16'd12);
      mem[1] = i_ins(6'h04, 0, 0, 16'd2);
      mem[4] = i_ins(6'h2B, 0, 3, 16'd8);
      mem[5] = i_ins(6'h23, 0, 4, 16'd8);
      mem[6] = HALT;
      slow_addr = 16'h0008; slow_dly = 3;
      start_run();
      wait_halt("prog2", 80);
      chk("prog2_wr_cnt", 32'(wr_cnt), 32'd1);
      chk("prog2_waddr", last_waddr, 32'd8);
      chk("prog2_wdata", last_wdata, 32'h0000_000C);
      chk("prog2_r4", dut.rf_q[4], 32'd12);
      chk("prog2_retires", 32'(ret_cnt), 32'd5);
      if (stamps.size() == 5) begin
         chk("prog2_sw_cycles", 32'(stamps[2] - stamps[1]), 32'd7);
         chk("prog2_lw_cycles", 32'(stamps[3] - stamps[2]), 32'd8);
      end
      chk("prog2_bus_stable", 32'(viol), 32'd0);
      slow_addr = 16'hFFFF; slow_dly = 0;

      // baln taken (N=1) and not taken (N=0)
      for (int t = 0; t < 2; t++) begin
         clear_mem();
         mem[0] = i_ins(6'h0D, 0, 1, 16'd5);
         mem[1] = i_ins(6'h04, 0, 1, 16'd0);
         mem[2] = i_ins(6'h04, 0, 1, 16'd0);
         mem[3] = (t == 0) ? r_ins(0, 1, 5, 6'h22) : r_ins(1, 0, 5, 6'h22);
         mem[4] = i_ins(6'h1B, 0, 0, 16'd2);
         mem[5] = HALT; mem[6] = HALT; mem[7] = HALT;
         start_run();
         wait_halt($sformatf("baln%0d", t), 60);
         chk($sformatf("baln%0d_r5", t), dut.rf_q[5], (t == 0) ? 32'hFFFF_FFFB : 32'd5);
         chk($sformatf("baln%0d_r31", t), dut.rf_q[31], (t == 0) ? 32'h0000_0014 : 32'd0);
         chk($sformatf("baln%0d_final_pc", t), 32'(dbg_pc), (t == 0) ? 32'h20 : 32'h18);
         chk($sformatf("baln%0d_retires", t), 32'(ret_cnt), 32'd6);
      end

      // Faults: misaligned, out of range, opcode 0x3E, bad funct
      for (int t = 0; t < 4; t++) begin
         clear_mem();
         case (t)
            0: begin
               mem[0] = i_ins(6'h0D, 0, 2, 16'd2);
               mem[1] = i_ins(6'h23, 2, 4, 16'd0);
            end
            1: begin
               mem[0] = i_ins(6'h0D, 0, 2, 16'hFFFC);
               mem[1] = i_ins(6'h23, 2, 4, 16'd4);
            end
            2: mem[0] = 32'hF800_0000;
            default: mem[0] = r_ins(1, 2, 3, 6'h21);
         endcase
         mem[2] = HALT;
         start_run();
         wait_halt($sformatf("fault%0d", t), 40);
         chk($sformatf("fault%0d_halted_err", t), {30'd0, halted, err}, 32'b11);
         chk($sformatf("fault%0d_req_cycles", t), 32'(req_cyc), (t < 2) ? 32'd2 : 32'd1);
         chk($sformatf("fault%0d_retires", t), 32'(ret_cnt), (t < 2) ? 32'd1 : 32'd0);
      end

      // Exactly WAIT_MAX stalls is tolerated
      clear_mem();
      mem[0] = i_ins(6'h23, 0, 4, 16'h0040);
      mem[1] = HALT;
      mem[16] = 32'hCAFE_0001;
      slow_addr = 16'h0040; slow_dly = WMAX;
      start_run();
      wait_halt("wmax_ok", 80);
      chk("wmax_ok_err", {31'd0, err}, 32'd0);
      chk("wmax_ok_r4", dut.rf_q[4], 32'hCAFE_0001);
      chk("wmax_ok_halt_cycle", 32'(halt_cyc), 32'd17);

      // One stall beyond WAIT_MAX halts with err, and HALT holds
      slow_dly = 1000;
      start_run();
      wait_halt("wmax_over", 80);
      chk("wmax_over_halted_err", {30'd0, halted, err}, 32'b11);
      chk("wmax_over_halt_cycle", 32'(halt_cyc), 32'd14);
      r = req_cyc;
      repeat (20) @(negedge clk);
      chk("halt_absorbing_req", 32'(req_cyc - r), 32'd0);
      chk("halt_absorbing_state", {30'd0, halted, err}, 32'b11);

      // Reset pulsed in the middle of a stalled load
      start_run();
      repeat (8) @(negedge clk);
      chk("midstall_req_before", {31'd0, bus.mem_req}, 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("midrst_mem_req", {31'd0, bus.mem_req}, 32'd0);
      chk("midrst_mem_addr", 32'(bus.mem_addr), 32'd0);
      chk("midrst_dbg_pc", 32'(dbg_pc), 32'd0);
      chk("midrst_flags", {29'd0, retire, halted, err}, 32'd0);
      chk("midrst_r4", dut.rf_q[4], 32'd0);
      slow_dly = 0;
      start_run();
      #1;
      chk("refetch_req", {31'd0, bus.mem_req}, 32'd1);
      chk("refetch_addr", 32'(bus.mem_addr), 32'd0);
      wait_halt("refetch", 40);
      chk("refetch_err", {31'd0, err}, 32'd0);
      chk("refetch_r4", dut.rf_q[4], 32'hCAFE_0001);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
